// File: rtl/layer_4_maxpool2x2_pkg.sv
// Shared constants and helpers for the layer-4 2x2 max-pool stage.
// Holds the fp32 field layout, the per-layer image sizes and the pixel-position
// classification used to steer each incoming beat.
package layer_4_maxpool2x2_pkg;

  localparam int FP32_WIDTH      = 32;
  localparam int FP32_SIGN_BIT   = 31;
  localparam int LAYER4_IMG_SIZE = 104;

  // What an incoming pixel does, decided purely by its column/row parity.
  typedef enum logic [1:0] {
    POS_PAIR_LATCH = 2'd0,  // even column: remember it as the left half of a pair
    POS_LB_WRITE   = 2'd1,  // odd column, even row: park the pair max in the line buffer
    POS_EMIT       = 2'd2   // odd column, odd row: last pixel of a 2x2 window
  } pos_e;

  function automatic pos_e classify_pos(input logic col_odd, input logic row_odd);
    pos_e p;
    if (!col_odd) begin
      p = POS_PAIR_LATCH;
    end else if (!row_odd) begin
      p = POS_LB_WRITE;
    end else begin
      p = POS_EMIT;
    end
    return p;
  endfunction

endpackage

// File: rtl/layer_4_maxpool2x2_fp32_max2.sv
// Combinational max of two fp32 words using only bit comparisons.
// Positive beats negative (+0 beats -0); among positives the larger
// magnitude wins, among negatives the smaller magnitude wins. NaN/Inf get
// no special treatment.
module fp32_max2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  logic                  sign_a_s;
  logic                  sign_b_s;
  logic [DATA_WIDTH-2:0] mag_a_s;
  logic [DATA_WIDTH-2:0] mag_b_s;

  assign sign_a_s = a_i[DATA_WIDTH-1];
  assign sign_b_s = b_i[DATA_WIDTH-1];
  assign mag_a_s  = a_i[DATA_WIDTH-2:0];
  assign mag_b_s  = b_i[DATA_WIDTH-2:0];

  // Pick the larger operand by sign first, then by magnitude ordering.
  always_comb begin
    y_o = a_i;
    if (sign_a_s != sign_b_s) begin
      y_o = sign_a_s ? b_i : a_i;
    end else if (!sign_a_s) begin
      y_o = (mag_a_s >= mag_b_s) ? a_i : b_i;
    end else begin
      y_o = (mag_a_s <= mag_b_s) ? a_i : b_i;
    end
  end

endmodule

// File: rtl/layer_4_maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pool for layer-4 fp32 feature maps.
// Raster-order input, one beat per cycle at most, no backpressure. Even-row
// pair maxima are parked in a half-width line buffer and combined with the
// odd-row pair; the pooled pixel is registered one cycle after the window's
// fourth pixel.
module layer_4_maxpool2x2
  import layer_4_maxpool2x2_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH,
  parameter int IMG_SIZE   = LAYER4_IMG_SIZE
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int CW       = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int LB_DEPTH = (IMG_SIZE / 2 > 0) ? IMG_SIZE / 2 : 1;
  localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_SIZE - 1);

  if ((IMG_SIZE % 2) != 0) begin : g_img_size_odd
    $error("layer_4_maxpool2x2: IMG_SIZE must be even");
  end

  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] p_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_out_q;
  logic [DATA_WIDTH-1:0] lb_q [LB_DEPTH];

  logic [LW-1:0]         lb_idx_s;
  logic [DATA_WIDTH-1:0] lb_rd_s;
  logic [DATA_WIDTH-1:0] row_pair_max_s;
  logic [DATA_WIDTH-1:0] lb_p_max_s;
  logic [DATA_WIDTH-1:0] window_max_s;
  pos_e                  pos_s;

  assign lb_idx_s = LW'(col_q >> 1);
  assign lb_rd_s  = lb_q[lb_idx_s];
  assign pos_s    = classify_pos(col_q[0], row_q[0]);

  // Even-row pair: P against the current (odd-column) pixel.
  fp32_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_row_pair (
    .a_i (p_q),
    .b_i (data_in),
    .y_o (row_pair_max_s)
  );

  // Upper-row pair max from the line buffer against P of the lower row.
  fp32_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_lb_combine (
    .a_i (lb_rd_s),
    .b_i (p_q),
    .y_o (lb_p_max_s)
  );

  // Fold in the fourth window pixel.
  fp32_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_final (
    .a_i (lb_p_max_s),
    .b_i (data_in),
    .y_o (window_max_s)
  );

  // Raster position next-state: advance on valid beats, wrap column then row.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        if (row_q == LAST_IDX) begin
          row_d = '0;
        end else begin
          row_d = row_q + CW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Position counters, pair latch and registered pooled output.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      col_q       <= '0;
      row_q       <= '0;
      p_q         <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      valid_out_q <= 1'b0;
      if (valid_in) begin
        case (pos_s)
          POS_PAIR_LATCH: p_q <= data_in;
          POS_LB_WRITE:   p_q <= p_q;
          POS_EMIT: begin
            data_out_q  <= window_max_s;
            valid_out_q <= 1'b1;
          end
          default:        p_q <= p_q;
        endcase
      end
    end
  end

  // Line buffer: one pair max per output column, written on even rows only.
  always_ff @(posedge Clk) begin
    if (!Rst && valid_in && (pos_s == POS_LB_WRITE)) begin
      lb_q[lb_idx_s] <= row_pair_max_s;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_layer_4_maxpool2x2.sv
// Bench for layer_4_maxpool2x2: table-driven 4x4 frames, a mid-frame reset
// sequence, and two back-to-back random 104x104 frames against a
// reference model built on an fp32 ordering key.
module tb_layer_4_maxpool2x2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc++;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT at IMG_SIZE=4 ----------------
  logic        rst4 = 1'b1;
  logic [31:0] din4 = 32'h0;
  logic        vin4 = 1'b0;
  logic [31:0] dout4;
  logic        vout4;

  layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) dut4 (
    .Clk(Clk), .Rst(rst4), .data_in(din4), .valid_in(vin4),
    .data_out(dout4), .valid_out(vout4)
  );

  // ---------------- DUT at IMG_SIZE=104 ----------------
  logic        rst104 = 1'b1;
  logic [31:0] din104 = 32'h0;
  logic        vin104 = 1'b0;
  logic [31:0] dout104;
  logic        vout104;

  layer_4_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(104)) dut104 (
    .Clk(Clk), .Rst(rst104), .data_in(din104), .valid_in(vin104),
    .data_out(dout104), .valid_out(vout104)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // fp32 ordering key: maps bit patterns onto integers so that numeric
  // order (with -0 just below +0) becomes plain integer order.
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? (-m - 64'sd1) : m;
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (fkey(a) >= fkey(b)) ? a : b;
  endfunction

  // Small positive integer -> fp32 bits.
  function automatic logic [31:0] to_fp(input int n);
    int e;
    logic [22:0] mant;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    mant = 23'((n - (1 << e)) << (23 - e));
    return {1'b0, 8'(e + 127), mant};
  endfunction

  // ---------------- capture of dut4 outputs ----------------
  logic [31:0] cap_val[$];
  int unsigned cap_cyc[$];

  always @(negedge Clk) begin
    if (vout4 === 1'b1) begin
      cap_val.push_back(dout4);
      cap_cyc.push_back(cyc);
    end
  end

  logic [31:0] cur_px [16];
  int unsigned beat_cyc [16];

  // Drive one 4x4 frame; beat_cyc records the posedge that samples each beat.
  task automatic run_frame4(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      din4 = cur_px[i];
      vin4 = 1'b1;
      beat_cyc[i] = cyc + 1;
      if (gaps) begin
        @(negedge Clk);
        vin4 = 1'b0;
        din4 = 32'hDEAD_BEEF;
      end
    end
    @(negedge Clk);
    vin4 = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic check_frame4(input string name, input logic [31:0] exp [4]);
    int last_idx [4];
    last_idx = '{5, 7, 13, 15};
    check_int({name, " count"}, cap_val.size(), 4);
    for (int w = 0; w < 4 && w < cap_val.size(); w++) begin
      check32($sformatf("%s win%0d value", name, w), cap_val[w], exp[w]);
      check_int($sformatf("%s win%0d latency", name, w), cap_cyc[w], beat_cyc[last_idx[w]]);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] px  [16];
    logic [31:0] exp [4];
    bit          gaps;
  } vec_t;

  vec_t vecs [4];

  // ---------------- reference model for dut104 ----------------
  typedef struct {
    int          frame;
    logic [31:0] val;
    int unsigned at_cyc;
  } exp_t;

  exp_t        exp104[$];
  logic [31:0] img [104][104];
  int          out_cnt [2];

  always @(negedge Clk) begin
    if (vout104 === 1'b1) begin
      if (exp104.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL img104 unexpected valid_out: got %08h at cycle %0d, expected none", dout104, cyc);
      end else begin
        exp_t e;
        e = exp104.pop_front();
        check32("img104 value", dout104, e.val);
        check_int("img104 latency", cyc, e.at_cyc);
        out_cnt[e.frame]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pooled [4];

    // ---- vector table ----
    vecs[0].name = "ramp";
    vecs[0].gaps = 1'b0;
    for (int i = 0; i < 16; i++) vecs[0].px[i] = to_fp(i + 1);
    vecs[0].exp = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

    vecs[1].name = "neg_ramp";
    vecs[1].gaps = 1'b0;
    for (int i = 0; i < 16; i++) vecs[1].px[i] = to_fp(i + 1) | 32'h80000000;
    vecs[1].exp = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};

    vecs[2].name = "mixed_sign";
    vecs[2].gaps = 1'b0;
    for (int i = 0; i < 16; i++) vecs[2].px[i] = 32'hC2C80000;
    vecs[2].px[0]  = 32'hC0000000;
    vecs[2].px[1]  = 32'h3F000000;
    vecs[2].px[4]  = 32'h80000000;
    vecs[2].px[5]  = 32'hC1000000;
    vecs[2].px[10] = 32'h00000000;
    vecs[2].px[11] = 32'h80000000;
    vecs[2].px[14] = 32'hBF800000;
    vecs[2].px[15] = 32'hC0000000;
    vecs[2].exp = '{32'h3F000000, 32'hC2C80000, 32'hC2C80000, 32'h00000000};

    vecs[3].name = "ramp_gaps";
    vecs[3].gaps = 1'b1;
    vecs[3].px   = vecs[0].px;
    vecs[3].exp  = vecs[0].exp;

    // ---- reset state ----
    repeat (2) @(negedge Clk);
    check32("reset data_out", dout4, 32'h0);
    check_int("reset valid_out", vout4, 0);
    rst4   = 1'b0;
    @(negedge Clk);

    // ---- table-driven 4x4 frames ----
    for (int v = 0; v < 4; v++) begin
      cap_val.delete();
      cap_cyc.delete();
      cur_px = vecs[v].px;
      run_frame4(vecs[v].gaps);
      check_frame4(vecs[v].name, vecs[v].exp);
    end

    // ---- mid-frame reset, with a beat coinciding with Rst ----
    for (int i = 0; i < 16; i++) cur_px[i] = to_fp(i + 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge Clk);
      din4 = cur_px[i];
      vin4 = 1'b1;
    end
    @(negedge Clk);
    #1;
    cap_val.delete();
    cap_cyc.delete();
    rst4 = 1'b1;
    vin4 = 1'b1;
    din4 = 32'h447A0000;
    @(negedge Clk);
    rst4 = 1'b0;
    vin4 = 1'b0;
    check32("midreset data_out", dout4, 32'h0);
    check_int("midreset valid_out", vout4, 0);
    repeat (2) @(negedge Clk);
    check_int("midreset no stale output", cap_val.size(), 0);
    run_frame4(1'b0);
    pooled = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    check_frame4("after_reset", pooled);

    // ---- two back-to-back random 104x104 frames ----
    out_cnt = '{0, 0};
    rst104  = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < 104; r++) begin
        for (int c = 0; c < 104; c++) begin
          logic [31:0] rnd;
          rnd = $urandom;
          if ($urandom_range(0, 15) == 0) rnd = {rnd[31], 31'd0};
          @(negedge Clk);
          din104 = rnd;
          vin104 = 1'b1;
          img[r][c] = rnd;
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            exp_t e;
            e.frame  = f;
            e.val    = fmax(fmax(img[r-1][c-1], img[r-1][c]), fmax(img[r][c-1], img[r][c]));
            e.at_cyc = cyc + 1;
            exp104.push_back(e);
          end
        end
      end
    end
    @(negedge Clk);
    vin104 = 1'b0;
    repeat (4) @(negedge Clk);
    check_int("img104 frame0 outputs", out_cnt[0], 2704);
    check_int("img104 frame1 outputs", out_cnt[1], 2704);
    check_int("img104 pending expectations", exp104.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
